// File: rtl/cfglut6_pkg.sv
// cfglut6_pkg: shared types and constants for the run-time reconfigurable LUT6.
//   state_e    - loader FSM states (IDLE, SHIFT)
//   TABLE_W    - truth table width (64)
//   CNT_W      - shift counter width (6)
//   lut_index  - packs I5..I0 into the 6-bit lookup index
package cfglut6_pkg;
  localparam int TABLE_W = 64;
  localparam int CNT_W   = 6;

  typedef enum logic {IDLE, SHIFT} state_e;

  function automatic logic [CNT_W-1:0] lut_index(
    input logic i5, input logic i4, input logic i3,
    input logic i2, input logic i1, input logic i0
  );
    return {i5, i4, i3, i2, i1, i0};
  endfunction
endpackage

// File: rtl/cfglut6_table.sv
// cfglut6_table: 64-bit truth table storage with serial shift-in and read mux.
//   i_clk       clock
//   i_rst       synchronous active-high reset, table reverts to INIT
//   i_shift_en  shift one bit in at this edge
//   i_shift_din bit shifted into position 0
//   i_idx       lookup index
//   o_o         combinational table[i_idx]
//   o_cdo       table[63], cascade/serial out
module cfglut6_table
  import cfglut6_pkg::*;
#(
  parameter logic [TABLE_W-1:0] INIT = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_shift_en,
  input  logic             i_shift_din,
  input  logic [CNT_W-1:0] i_idx,
  output logic             o_o,
  output logic             o_cdo
);
  logic [TABLE_W-1:0] r_tbl;

  always_ff @(posedge i_clk) begin
    if (i_rst)           r_tbl <= INIT;
    else if (i_shift_en) r_tbl <= {r_tbl[TABLE_W-2:0], i_shift_din};
  end

  // No masking during a load: partially shifted contents are visible.
  assign o_o   = r_tbl[i_idx];
  assign o_cdo = r_tbl[TABLE_W-1];
endmodule

// File: rtl/cfglut6_loader.sv
// cfglut6_loader: LUT6 with a valid/ready serial loader that shifts a new
// 64-bit truth table in MSB first, one bit per clock (64 cycles).
//   CLK, RST              clock, synchronous active-high reset
//   I0..I5                lookup index {I5..I0}
//   LOAD_VALID/READY/DATA table load handshake; DATA sampled on accept edge
//   BUSY                  shift in progress
//   O, OQ, CDO            comb lookup, registered lookup, table[63]
//   CE, CDI               direct serial shift in IDLE, only when
//                         CFGLUT6_DIRECT_CDI_EN is defined
module cfglut6_loader
  import cfglut6_pkg::*;
#(
  parameter logic [TABLE_W-1:0] INIT = 64'h0000000000000000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               I0,
  input  logic               I1,
  input  logic               I2,
  input  logic               I3,
  input  logic               I4,
  input  logic               I5,
  input  logic               LOAD_VALID,
  output logic               LOAD_READY,
  input  logic [TABLE_W-1:0] LOAD_DATA,
  output logic               BUSY,
`ifdef CFGLUT6_DIRECT_CDI_EN
  input  logic               CE,
  input  logic               CDI,
`endif
  output logic               O,
  output logic               OQ,
  output logic               CDO
);
  state_e             r_state, w_next;
  logic [TABLE_W-1:0] r_s;
  logic [CNT_W-1:0]   r_c;
  logic               w_shift_en, w_shift_din, w_accept, w_o;
  logic [CNT_W-1:0]   w_idx;

  assign w_idx    = lut_index(I5, I4, I3, I2, I1, I0);
  assign w_accept = (r_state == IDLE) && LOAD_VALID;

  always_comb begin
    w_next      = r_state;
    LOAD_READY  = 1'b0;
    BUSY        = 1'b0;
    w_shift_en  = 1'b0;
    w_shift_din = 1'b0;
    unique case (r_state)
      IDLE: begin
        LOAD_READY = 1'b1;
        if (LOAD_VALID) w_next = SHIFT;
`ifdef CFGLUT6_DIRECT_CDI_EN
        // A load offer takes precedence over the direct serial port.
        else if (CE) begin
          w_shift_en  = 1'b1;
          w_shift_din = CDI;
        end
`endif
      end
      SHIFT: begin
        BUSY        = 1'b1;
        w_shift_en  = 1'b1;
        w_shift_din = r_s[TABLE_W-1];
        if (r_c == {CNT_W{1'b1}}) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_c     <= '0;
      OQ      <= 1'b0;
    end else begin
      r_state <= w_next;
      OQ      <= w_o;
      if (w_accept) begin
        r_s <= LOAD_DATA;
        r_c <= '0;
      end else if (r_state == SHIFT) begin
        r_s <= r_s << 1;
        r_c <= r_c + CNT_W'(1);
      end
    end
  end

  cfglut6_table #(.INIT(INIT)) u_table (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_shift_en (w_shift_en),
    .i_shift_din(w_shift_din),
    .i_idx      (w_idx),
    .o_o        (w_o),
    .o_cdo      (CDO)
  );

  assign O = w_o;
endmodule

// File: tb/tb_cfglut6_loader.sv
module tb_cfglut6_loader;
  localparam logic [63:0] INIT_A = 64'h8000000000000001;
  localparam logic [63:0] INIT_B = 64'h0;

  logic        CLK = 1'b0, RST = 1'b1, LOAD_VALID = 1'b0, CE = 1'b0, CDI = 1'b0;
  logic [63:0] LOAD_DATA = '0;
  logic [5:0]  idx = '0;
  logic        rdy_a, busy_a, o_a, oq_a, cdo_a;
  logic        rdy_b, busy_b, o_b, oq_b, cdo_b;

  int checks = 0, errors = 0;

  always #5 CLK = ~CLK;

  cfglut6_loader #(.INIT(INIT_A)) dut (
    .CLK(CLK), .RST(RST), .I0(idx[0]), .I1(idx[1]), .I2(idx[2]), .I3(idx[3]),
    .I4(idx[4]), .I5(idx[5]), .LOAD_VALID(LOAD_VALID), .LOAD_READY(rdy_a),
    .LOAD_DATA(LOAD_DATA), .BUSY(busy_a),
`ifdef CFGLUT6_DIRECT_CDI_EN
    .CE(CE), .CDI(CDI),
`endif
    .O(o_a), .OQ(oq_a), .CDO(cdo_a));

  cfglut6_loader #(.INIT(INIT_B)) dut0 (
    .CLK(CLK), .RST(RST), .I0(idx[0]), .I1(idx[1]), .I2(idx[2]), .I3(idx[3]),
    .I4(idx[4]), .I5(idx[5]), .LOAD_VALID(LOAD_VALID), .LOAD_READY(rdy_b),
    .LOAD_DATA(LOAD_DATA), .BUSY(busy_b),
`ifdef CFGLUT6_DIRECT_CDI_EN
    .CE(CE), .CDI(CDI),
`endif
    .O(o_b), .OQ(oq_b), .CDO(cdo_b));

  // Reference model: table contents as a function of how many bits of the
  // accepted word have been shifted in, rather than bit-by-bit registers.
  logic [63:0] m_tbl [2];
  logic [63:0] m_old [2];
  logic        m_oq  [2];
  logic [63:0] m_data;
  logic        m_busy = 1'b0;
  int          m_k = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("ready_a", 64'(rdy_a), 64'(!m_busy));
    chk("busy_a",  64'(busy_a), 64'(m_busy));
    chk("o_a",     64'(o_a),   64'(m_tbl[0][idx]));
    chk("oq_a",    64'(oq_a),  64'(m_oq[0]));
    chk("cdo_a",   64'(cdo_a), 64'(m_tbl[0][63]));
    chk("busy_b",  64'(busy_b), 64'(m_busy));
    chk("o_b",     64'(o_b),   64'(m_tbl[1][idx]));
    chk("oq_b",    64'(oq_b),  64'(m_oq[1]));
    chk("cdo_b",   64'(cdo_b), 64'(m_tbl[1][63]));
  endtask

  task automatic step();
    logic r, v, ce, cdi;
    logic [63:0] d;
    logic [5:0] ix;
    r = RST; v = LOAD_VALID; d = LOAD_DATA; ix = idx; ce = CE; cdi = CDI;
    @(posedge CLK);
    if (r) begin
      m_busy = 1'b0;
      m_tbl[0] = INIT_A; m_tbl[1] = INIT_B;
      m_oq[0] = 1'b0; m_oq[1] = 1'b0;
    end else begin
      for (int j = 0; j < 2; j++) m_oq[j] = m_tbl[j][ix];
      if (m_busy) begin
        m_k++;
        for (int j = 0; j < 2; j++)
          m_tbl[j] = (m_k == 64) ? m_data : ((m_old[j] << m_k) | (m_data >> (64 - m_k)));
        if (m_k == 64) m_busy = 1'b0;
      end else if (v) begin
        m_busy = 1'b1; m_k = 0; m_data = d;
        for (int j = 0; j < 2; j++) m_old[j] = m_tbl[j];
      end
`ifdef CFGLUT6_DIRECT_CDI_EN
      else if (ce) begin
        for (int j = 0; j < 2; j++) m_tbl[j] = {m_tbl[j][62:0], cdi};
      end
`endif
    end
    #1;
    check_all();
  endtask

  task automatic sweep(input string nm, input logic [63:0] ea, input logic [63:0] eb);
    for (int i = 0; i < 64; i++) begin
      idx = 6'(i);
      #1;
      chk({nm, "_a"}, 64'(o_a), 64'(ea[i]));
      chk({nm, "_b"}, 64'(o_b), 64'(eb[i]));
    end
  endtask

  task automatic run_until_idle(input string nm, input int exp_len);
    int n = 0;
    while (busy_a && n < 200) begin
      idx = 6'($urandom_range(0, 63));
      step();
      n++;
    end
    chk(nm, 64'(n), 64'(exp_len));
  endtask

  typedef struct { logic [5:0] idx; logic exp_a; logic exp_b; } vec_t;
  vec_t vecs [5];

  initial begin
    logic [63:0] w1, w2;
    int n;
    m_tbl[0] = 'x; m_tbl[1] = 'x; m_oq[0] = 1'b0; m_oq[1] = 1'b0;
    vecs[0] = '{6'd0,  1'b1, 1'b0};
    vecs[1] = '{6'd63, 1'b1, 1'b0};
    vecs[2] = '{6'd5,  1'b0, 1'b0};
    vecs[3] = '{6'd62, 1'b0, 1'b0};
    vecs[4] = '{6'd1,  1'b0, 1'b0};

    // Reset; hold idx=0 so the first post-reset edge captures a 1 into OQ.
    @(negedge CLK);
    step(); step();
    RST = 1'b0;
    chk("reset_oq", 64'(oq_a), 64'd0);
    chk("reset_ready", 64'(rdy_a), 64'd1);
    chk("reset_busy", 64'(busy_a), 64'd0);
    chk("reset_cdo", 64'(cdo_a), 64'd1);
    for (int i = 0; i < 5; i++) begin
      idx = vecs[i].idx;
      #1;
      chk("vec_o_a", 64'(o_a), 64'(vecs[i].exp_a));
      chk("vec_o_b", 64'(o_b), 64'(vecs[i].exp_b));
    end
    idx = 6'd0;
    step();
    chk("oq_after_edge", 64'(oq_a), 64'd1);

    // Fixed word load: BUSY for exactly 64 cycles, then full sweep.
    w1 = 64'hDEADBEEFCAFEF00D;
    LOAD_VALID = 1'b1; LOAD_DATA = w1;
    step();
    LOAD_VALID = 1'b0; LOAD_DATA = {$urandom, $urandom};
    run_until_idle("busy_len_fixed", 64);
    sweep("sweep_fixed", w1, w1);
    chk("cdo_fixed", 64'(cdo_a), 64'd1);

    // Offer held during SHIFT with a different word; accepted only at E65.
    w1 = {$urandom, $urandom}; w2 = {$urandom, $urandom};
    LOAD_VALID = 1'b1; LOAD_DATA = w1;
    step();
    LOAD_DATA = w2;
    run_until_idle("busy_len_first", 64);
    chk("ready_between", 64'(rdy_a), 64'd1);
    step();
    chk("second_accept", 64'(busy_a), 64'd1);
    LOAD_VALID = 1'b0; LOAD_DATA = {$urandom, $urandom};
    run_until_idle("busy_len_second", 64);
    sweep("sweep_second", w2, w2);

    // Randomized loads with random gaps and random lookups.
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(0, 4);
      for (int g = 0; g < n; g++) begin
        idx = 6'($urandom_range(0, 63));
        step();
      end
      LOAD_VALID = 1'b1; LOAD_DATA = {$urandom, $urandom};
      step();
      LOAD_VALID = 1'b0;
      run_until_idle("busy_len_rand", 64);
    end

    // Reset at shift cycle 30: load discarded, both tables back to INIT.
    LOAD_VALID = 1'b1; LOAD_DATA = {$urandom, $urandom} | 64'h1;
    step();
    LOAD_VALID = 1'b0;
    for (int i = 0; i < 30; i++) step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("rst_mid_busy", 64'(busy_a), 64'd0);
    chk("rst_mid_ready", 64'(rdy_a), 64'd1);
    sweep("sweep_rst_mid", INIT_A, INIT_B);

`ifdef CFGLUT6_DIRECT_CDI_EN
    CE = 1'b1; CDI = 1'b1;
    for (int i = 0; i < 3; i++) step();
    CE = 1'b0; CDI = 1'b0;
    sweep("sweep_cdi", {INIT_A[60:0], 3'b111}, 64'h7);
    w1 = {$urandom, $urandom};
    CE = 1'b1; CDI = 1'b1; LOAD_VALID = 1'b1; LOAD_DATA = w1;
    step();
    CE = 1'b0; LOAD_VALID = 1'b0;
    chk("ce_vs_load_busy", 64'(busy_a), 64'd1);
    run_until_idle("busy_len_ce", 64);
    sweep("sweep_ce_load", w1, w1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule

// File: doc/cfglut6_loader.md
# cfglut6_loader

Run-time reconfigurable 6-input LUT with an integrated serial loader, for Verilator simulation of designs that rewrite LUT contents in-system. It sits directly upstream of a LUT6_D-style lookup. A 64-bit truth table is accepted over a valid/ready handshake and shifted into table storage one bit per clock, as CFGLUT hardware does. The block drives combinational and registered lookup outputs from the current table contents at all times.

## Interface
- INIT, 64'h0000000000000000: truth table value after reset.
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  reset, synchronous, active-high.
- I0..I5  input  1 each  lookup address; index = {I5,I4,I3,I2,I1,I0}.
- LOAD_VALID  input  1  new table offered.
- LOAD_READY  output  1  loader idle, can accept.
- LOAD_DATA  input  64  new truth table; bit n is the output for index n.
- BUSY  output  1  shift in progress.
- O  output  1  combinational table[index].
- OQ  output  1  registered table[index].
- CDO  output  1  table[63]; cascade/serial out.
- CE, CDI  input  1 each  direct serial shift port; present only with CFGLUT6_DIRECT_CDI_EN.

## Operation
- Storage: 64-bit table T, shift buffer S (64 bits), 6-bit counter C, FSM {IDLE, SHIFT}.
- IDLE: LOAD_READY=1, BUSY=0. If LOAD_VALID=1 at an edge, then S<=LOAD_DATA, C<=0, and the FSM moves to SHIFT.
- SHIFT: LOAD_READY=0, BUSY=1. At each edge, T<={T[62:0],S[63]}, S<=S<<1, C<=C+1. On the edge where C==63, the FSM returns to IDLE. After that edge, T==LOAD_DATA exactly.
- O = T[index] at all times, including the partially shifted contents during SHIFT. No masking.
- OQ <= T[index] at every edge, using the pre-edge T.
- CDO = T[63] at all times.
- LOAD_VALID while in SHIFT: ignored, not queued. The offering side holds it until LOAD_READY.
- LOAD_DATA is sampled only on the accept edge. Later changes have no effect.

## Timing
- Reset values: T=INIT, S=0, C=0, FSM=IDLE, OQ=0, LOAD_READY=1, BUSY=0. O and CDO follow T=INIT.
- Reset mid-shift: the partial load is discarded, T reverts to INIT, and the FSM returns to IDLE on the same edge. RST has priority over all other inputs.
- Load latency: accept at edge E0; shifts occur at E1..E64. BUSY is high for exactly 64 cycles. LOAD_READY is high again after E64, so the next accept can occur at E65.
- O updates combinationally after any edge that changes T, and after any change on I0..I5.
- OQ reflects an index presented before edge N at the output after edge N (1-cycle latency).
- C wraps 63→0 only by the FSM exit. C is never read in IDLE.

## Configuration
- CFGLUT6_DIRECT_CDI_EN defined: the CE and CDI ports exist. In IDLE with CE=1 and LOAD_VALID=0, T<={T[62:0],CDI} at the edge. CE is ignored in SHIFT. LOAD_VALID wins over CE when both are asserted in the same IDLE cycle.
- Not defined: there are no CE or CDI ports, and T changes only via reset or the loader.

## Structure
- Package cfglut6_pkg holds:
  - the state enum (IDLE, SHIFT);
  - localparams TABLE_W=64 and CNT_W=6;
  - the function lut_index(I5..I0) returning the 6-bit index.
- Sub-module cfglut6_table holds T with shift-in (enable, data-in), the read mux (O), and CDO. The top level holds the FSM, S, C, OQ and the handshake.

## Test plan
- Reset with INIT=64'h8000000000000001, idle: index 0 → O=1; index 63 → O=1; index 5 → O=0; OQ=0 until the first post-reset edge.
- Load LOAD_DATA=64'hDEADBEEFCAFEF00D: BUSY is high for exactly 64 cycles. After that, the sweep of all 64 indices matches LOAD_DATA, and CDO=1.
- Hold LOAD_VALID with a different word during SHIFT: it is not accepted until LOAD_READY rises. The second load completes 64 cycles after its own accept edge.
- Assert RST at shift cycle 30 of a load with INIT=0: T=0, BUSY=0 and LOAD_READY=1 on the next cycle, and O=0 for all indices.
- With CFGLUT6_DIRECT_CDI_EN, in IDLE: hold CE=1 and CDI=1 for 3 cycles from T=0 → T=64'h7. Assert CE and LOAD_VALID in the same cycle → the loader accepts and CE has no effect.
